// File: rtl/ldl_round_wrr.sv
// ---------------------------------------------------------------------------
// ldl_round_wrr -- weighted round-robin arbiter
//
// Each requester keeps its grant for up to weight[i] accepted beats (a beat is
// one cycle with take=1). The grant is released early if the holder drops
// its request. On release the search pointer moves one past the released
// index, and arbitration runs again in the same edge, so there is no idle
// bubble between grants.
//
// Parameters
//   WIDTH  number of requesters (>= 2, need not be a power of two)
//   WW     bit width of each weight field
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   req     request vector, bit i = requester i (level-sensitive)
//   weight  packed weights, requester i uses [i*WW +: WW]; 0 counts as 1
//   take    downstream accepts one beat of the current grant this cycle
//   ack     grant valid (registered)
//   bin     granted index (registered)
//   hot     one-hot grant (registered), zero when ack=0
//   last    current beat is the final one of this grant
// ---------------------------------------------------------------------------
module ldl_round_wrr #(
  parameter int WIDTH = 8,
  parameter int WW    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           req,
  input  logic [WIDTH*WW-1:0]        weight,
  input  logic                       take,
  output logic                       ack,
  output logic [$clog2(WIDTH)-1:0]   bin,
  output logic [WIDTH-1:0]           hot,
  output logic                       last
);

  localparam int BW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_ack;
  logic [BW-1:0]   r_bin;
  logic [WIDTH-1:0] r_hot;
  logic [WW-1:0]   r_credit;
  logic [BW-1:0]   r_next;

  logic            w_rel;
  logic [BW-1:0]   w_start;
  logic            w_hit;
  logic [BW-1:0]   w_idx;
  logic [WW-1:0]   w_wt;

  // A zero weight would otherwise yield a grant that can never retire a beat.
  function automatic logic [WW-1:0] eff_weight(input logic [WW-1:0] w);
    return (w == '0) ? WW'(1) : w;
  endfunction

  // Release decision and circular search. While granted, the search base is
  // the index after the current holder, which becomes the new pointer if the
  // grant is released this edge.
  always_comb begin
    w_rel   = 1'b0;
    w_start = r_next;
    if (r_state == S_GRANT) begin
      w_start = (r_bin == BW'(WIDTH - 1)) ? '0 : r_bin + 1'b1;
      w_rel   = !req[r_bin] || (take && (r_credit == WW'(1)));
    end

    // Walk offsets from farthest to nearest so the nearest hit wins.
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      int p;
      p = int'(w_start) + k;
      if (p >= WIDTH) p = p - WIDTH;
      if (req[p]) begin
        w_hit = 1'b1;
        w_idx = BW'(p);
      end
    end

    w_wt = eff_weight(weight[int'(w_idx)*WW +: WW]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_bin    <= '0;
      r_hot    <= '0;
      r_credit <= '0;
      r_next   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_state  <= S_GRANT;
            r_ack    <= 1'b1;
            r_bin    <= w_idx;
            r_hot    <= WIDTH'(1) << w_idx;
            r_credit <= w_wt;
          end
        end
        S_GRANT: begin
          if (w_rel) begin
            // Withdraw or exhaust: rotate and re-arbitrate in the same edge.
            r_next <= w_start;
            if (w_hit) begin
              r_ack    <= 1'b1;
              r_bin    <= w_idx;
              r_hot    <= WIDTH'(1) << w_idx;
              r_credit <= w_wt;
            end else begin
              r_state <= S_IDLE;
              r_ack   <= 1'b0;
              r_hot   <= '0;
            end
          end else if (take) begin
            // Credit > 1 here, so this cannot underflow.
            r_credit <= r_credit - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack  = r_ack;
  assign bin  = r_bin;
  assign hot  = r_hot;
  assign last = r_ack && (r_credit == WW'(1));

endmodule

// File: tb/tb_ldl_round_wrr.sv
module tb_ldl_round_wrr;

  localparam int W  = 8;
  localparam int WW = 4;
  localparam int BW = $clog2(W);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    req;
  logic [W*WW-1:0] weight;
  logic            take;
  logic            ack;
  logic [BW-1:0]   bin;
  logic [W-1:0]    hot;
  logic            last;

  always #5 clk = ~clk;

  ldl_round_wrr #(.WIDTH(W), .WW(WW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .weight (weight),
    .take   (take),
    .ack    (ack),
    .bin    (bin),
    .hot    (hot),
    .last   (last)
  );

  typedef struct {
    logic          ack;
    logic [BW-1:0] bin;
    logic [W-1:0]  hot;
    logic          last;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: who owns the resource, how many beats it may still
  // take, and where the next search begins.
  int owner = -1;
  int left  = 0;
  int ptr   = 0;

  function automatic int eff_w(int i);
    int v;
    v = int'(weight[i*WW +: WW]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int pick(int from);
    for (int k = 0; k < W; k++) begin
      int i;
      i = (from + k) % W;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1;
      left  = 0;
      ptr   = 0;
      q.delete();
    end else begin
      logic rel;
      exp_t e;
      rel = 1'b0;
      if (owner < 0) begin
        owner = pick(ptr);
        if (owner >= 0) left = eff_w(owner);
      end else if (!req[owner]) begin
        rel = 1'b1;
      end else if (take) begin
        left = left - 1;
        if (left == 0) rel = 1'b1;
      end
      if (rel) begin
        ptr   = (owner + 1) % W;
        owner = pick(ptr);
        if (owner >= 0) left = eff_w(owner);
      end
      e.ack  = (owner >= 0);
      e.bin  = (owner >= 0) ? BW'(owner) : '0;
      e.hot  = '0;
      if (owner >= 0) e.hot[owner] = 1'b1;
      e.last = (owner >= 0) && (left == 1);
      q.push_back(e);
    end
  end

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      checks++;
      if (ack !== 1'b0 || bin !== '0 || hot !== '0 || last !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: ack=%0b bin=%0d hot=%h last=%0b expected all zero",
                 cyc, ack, bin, hot, last);
      end
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (ack !== e.ack || hot !== e.hot || last !== e.last ||
          (e.ack && bin !== e.bin)) begin
        errors++;
        $display("FAIL grant cycle %0d: ack=%0b bin=%0d hot=%h last=%0b expected ack=%0b bin=%0d hot=%h last=%0b",
                 cyc, ack, bin, hot, last, e.ack, e.bin, e.hot, e.last);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 8'ha5;
    take   = 1'b1;
    weight = {W{4'h1}};
    cycles(4);
    #3 rst_n = 1'b1;

    // Plain rotation, all weights 1.
    cycles(12);

    // Weighted: w0=3, w2=1.
    weight = {W{4'h1}};
    weight[0*WW +: WW] = 4'd3;
    weight[2*WW +: WW] = 4'd1;
    req = 8'h05;
    cycles(15);

    // Stall pattern with w0=2.
    weight[0*WW +: WW] = 4'd2;
    req = 8'h01;
    for (int k = 0; k < 12; k++) begin
      take = (k % 4 == 0) || (k % 4 == 3);
      cycles(1);
    end
    take = 1'b1;

    // Withdrawal with w0=4.
    weight[0*WW +: WW] = 4'd4;
    for (int k = 0; k < 14; k++) begin
      req = (k == 2 || k == 3) ? 8'h04 : 8'h05;
      cycles(1);
    end

    // Zero weight behaves as one.
    weight[4*WW +: WW] = 4'd0;
    req = 8'h10;
    cycles(6);

    // Weight change mid-grant leaves current credit alone.
    req = 8'h00;
    cycles(2);
    weight[0*WW +: WW] = 4'd5;
    req = 8'h01;
    cycles(2);
    weight[0*WW +: WW] = 4'd1;
    cycles(8);

    // Asynchronous reset mid-grant clears outputs without a clock edge.
    req  = 8'hff;
    take = 1'b0;
    cycles(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || bin !== '0 || hot !== '0 || last !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ack=%0b bin=%0d hot=%h last=%0b expected all zero",
               ack, bin, hot, last);
    end
    cycles(1);
    #3 rst_n = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0:       req = W'($urandom);
        1:       req = W'($urandom & $urandom & $urandom);
        2:       req = (k % 7 == 0) ? W'($urandom) : req;
        default: req = W'(1) << $urandom_range(0, W - 1);
      endcase
      take = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) weight = $urandom;
    end

    req = '0;
    cycles(4);
    if (checks < 12) begin
      errors++;
      $display("FAIL check_count: got %0d comparisons, expected at least 12", checks);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
